// File: rtl/noc_flit_to_axis_depacketizer_if.sv
// noc_flit_to_axis_depacketizer_if: flit ejection and AXI4-Stream handshake bundles.
interface noc_flit_if #(
    parameter int FlitWidth = 64
);
    logic [FlitWidth-1:0] flit;
    logic [1:0]           flit_type;
    logic                 flit_valid;
    logic                 flit_ready;
    modport master (output flit, flit_type, flit_valid, input flit_ready);
    modport slave  (input flit, flit_type, flit_valid, output flit_ready);
endinterface

interface axis_if #(
    parameter int FlitWidth = 64,
    parameter int DestWidth = 4,
    parameter int IdWidth   = 4
);
    logic [FlitWidth-1:0] tdata;
    logic [DestWidth-1:0] tdest;
    logic [IdWidth-1:0]   tid;
    logic                 tlast;
    logic                 tvalid;
    logic                 tready;
    modport master (output tdata, tdest, tid, tlast, tvalid, input tready);
    modport slave  (input tdata, tdest, tid, tlast, tvalid, output tready);
endinterface

// File: rtl/noc_flit_to_axis_depacketizer.sv
// noc_flit_to_axis_depacketizer: rebuilds AXI4-Stream packets from header/body/tail NoC flits.
module noc_flit_to_axis_depacketizer #(
    parameter int FlitWidth  = 64,
    parameter int DestWidth  = 4,
    parameter int IdWidth    = 4,
    parameter int CountWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    noc_flit_if.slave             s_flit,
    axis_if.master                m_axis,
    output logic [CountWidth-1:0] pkt_count_o,
    output logic [CountWidth-1:0] err_count_o,
    output logic                  err_o
);
    typedef enum logic {IDLE, PAYLOAD} state_t;
    typedef struct packed {
        logic [FlitWidth-1:0] data;
        logic [DestWidth-1:0] dest;
        logic [IdWidth-1:0]   id;
        logic                 last;
    } beat_t;

    state_t               r_state, w_state_nx;
    logic [DestWidth-1:0] r_dest;
    logic [IdWidth-1:0]   r_id;
    beat_t                r_mem [2];
    logic                 r_wr_ptr, r_rd_ptr;
    logic [1:0]           r_occ;
    logic                 w_accept, w_pop, w_push, w_err, w_hdr, w_last;
    beat_t                w_head;

    // Ready comes only from registered occupancy, never from tready.
    assign s_flit.flit_ready = !rst_i && (r_occ != 2'd2);
    assign w_accept = s_flit.flit_valid && s_flit.flit_ready;
    assign w_pop    = m_axis.tvalid && m_axis.tready;
    assign w_last   = s_flit.flit_type == 2'b10;

    always_comb begin
        w_state_nx = r_state;
        w_push     = 1'b0;
        w_err      = 1'b0;
        w_hdr      = 1'b0;
        if (w_accept) begin
            if (r_state == IDLE) begin
                w_hdr      = s_flit.flit_type == 2'b00;
                w_err      = !w_hdr;
                w_state_nx = w_hdr ? PAYLOAD : IDLE;
            end else begin
                w_push     = s_flit.flit_type[0] ^ s_flit.flit_type[1];
                w_err      = !w_push;
                w_state_nx = w_last ? IDLE : PAYLOAD;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_dest      <= '0;
            r_id        <= '0;
            r_mem[0]    <= '0;
            r_mem[1]    <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_occ       <= 2'd0;
            pkt_count_o <= '0;
            err_count_o <= '0;
            err_o       <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_hdr) begin
                r_dest <= s_flit.flit[DestWidth-1:0];
                r_id   <= s_flit.flit[DestWidth+IdWidth-1:DestWidth];
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{data: s_flit.flit, dest: r_dest, id: r_id, last: w_last};
                r_wr_ptr        <= !r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= !r_rd_ptr;
            r_occ       <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            pkt_count_o <= pkt_count_o + CountWidth'(w_pop && w_head.last);
            err_count_o <= err_count_o + CountWidth'(w_err);
            err_o       <= w_err;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign m_axis.tdata  = w_head.data;
    assign m_axis.tdest  = w_head.dest;
    assign m_axis.tid    = w_head.id;
    assign m_axis.tlast  = w_head.last;
    assign m_axis.tvalid = r_occ != 2'd0;
endmodule
